ucie_stack_demultiplexer: RTL and testbench

UCIE_STACK_DEMULTIPLEXER -- requirements
Module: ucie_stack_demultiplexer

---
 rtl/ucie_stack_demultiplexer.sv | 126 ++++++++++++
 tb/tb_ucie_stack_demultiplexer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ucie_stack_demultiplexer.sv
// Steers inbound D2D flits into one small FIFO per protocol stack, with per-stack credits and drop accounting.
// Latency 1 cycle push-to-head; d2d_rx_ready drops only when the addressed, enabled stack's FIFO is full.
package ucie_pkg;
    localparam int FLIT_WIDTH = 64;
endpackage

module ucie_stack_demultiplexer #(
    parameter int NUM_STACKS     = 4,
    parameter int STACK_ID_WIDTH = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [ucie_pkg::FLIT_WIDTH-1:0]                   d2d_rx_flit,
    input  logic                                              d2d_rx_valid,
    output logic                                              d2d_rx_ready,
    input  logic [STACK_ID_WIDTH-1:0]                         d2d_rx_stack_id,
    output logic [NUM_STACKS-1:0][ucie_pkg::FLIT_WIDTH-1:0]   proto_rx_flit,
    output logic [NUM_STACKS-1:0]                             proto_rx_valid,
    input  logic [NUM_STACKS-1:0]                             proto_rx_ready,
    input  logic [NUM_STACKS-1:0]                             stack_enable,
    output logic [NUM_STACKS-1:0][7:0]                        fc_credits,
    input  logic                                              err_clear,
    output logic [15:0]                                       drop_count,
    output logic                                              rx_error,
    output logic [15:0]                                       demux_status
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = ucie_pkg::FLIT_WIDTH;

    logic [FW-1:0] mem_q [NUM_STACKS][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q [NUM_STACKS];
    logic [PW-1:0] wr_ptr_d [NUM_STACKS];
    logic [PW-1:0] rd_ptr_q [NUM_STACKS];
    logic [PW-1:0] rd_ptr_d [NUM_STACKS];
    logic [CW-1:0] count_q  [NUM_STACKS];
    logic [CW-1:0] count_d  [NUM_STACKS];
    logic [15:0]   drop_count_q, drop_count_d;
    logic          rx_error_q, rx_error_d;

    logic [NUM_STACKS-1:0] hit, full, push, pop;
    logic                  routable, sel_full, drop;

    // hit is one-hot or empty; an out-of-range id simply hits nothing.
    always_comb begin
        for (int i = 0; i < NUM_STACKS; i++) begin
            hit[i]  = (32'(d2d_rx_stack_id) == 32'(i));
            full[i] = (count_q[i] == CW'(FIFO_DEPTH));
        end
        routable     = |(hit & stack_enable);
        sel_full     = |(hit & full);
        d2d_rx_ready = !(d2d_rx_valid && routable && sel_full);
        push         = (d2d_rx_valid && !sel_full) ? (hit & stack_enable) : '0;
        drop         = d2d_rx_valid && !routable;
        pop          = proto_rx_valid & proto_rx_ready;
    end

    always_comb begin
        for (int i = 0; i < NUM_STACKS; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            if (!stack_enable[i]) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end else begin
                if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
                if (push[i] && !pop[i])      count_d[i] = count_q[i] + 1'b1;
                else if (!push[i] && pop[i]) count_d[i] = count_q[i] - 1'b1;
            end
        end
    end

    // A drop coincident with a clear leaves exactly that one drop recorded.
    always_comb begin
        drop_count_d = drop_count_q;
        rx_error_d   = rx_error_q;
        if (err_clear) begin
            drop_count_d = drop ? 16'd1 : 16'd0;
            rx_error_d   = drop;
        end else if (drop) begin
            if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
            rx_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STACKS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            drop_count_q <= '0;
            rx_error_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_STACKS; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            drop_count_q <= drop_count_d;
            rx_error_q   <= rx_error_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_STACKS; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= d2d_rx_flit;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_STACKS; i++) begin
            proto_rx_flit[i]  = mem_q[i][rd_ptr_q[i]];
            proto_rx_valid[i] = (count_q[i] != '0);
            fc_credits[i]     = stack_enable[i] ? 8'(CW'(FIFO_DEPTH) - count_q[i]) : 8'd0;
        end
        drop_count   = drop_count_q;
        rx_error     = rx_error_q;
        demux_status = {rx_error_q, 7'b0, 8'(full)};
    end
endmodule

// File: tb/tb_ucie_stack_demultiplexer.sv
// Directed bench for ucie_stack_demultiplexer with default parameters (4 stacks, depth 4, 64-bit flits).
module tb_ucie_stack_demultiplexer;
    logic              clk = 1'b0;
    logic              rst;
    logic [63:0]       d2d_rx_flit;
    logic              d2d_rx_valid;
    logic              d2d_rx_ready;
    logic [3:0]        d2d_rx_stack_id;
    logic [3:0][63:0]  proto_rx_flit;
    logic [3:0]        proto_rx_valid;
    logic [3:0]        proto_rx_ready;
    logic [3:0]        stack_enable;
    logic [3:0][7:0]   fc_credits;
    logic              err_clear;
    logic [15:0]       drop_count;
    logic              rx_error;
    logic [15:0]       demux_status;

    int n_checks = 0;
    int n_pass   = 0;

    ucie_stack_demultiplexer dut (
        .clk(clk), .rst(rst),
        .d2d_rx_flit(d2d_rx_flit), .d2d_rx_valid(d2d_rx_valid), .d2d_rx_ready(d2d_rx_ready),
        .d2d_rx_stack_id(d2d_rx_stack_id),
        .proto_rx_flit(proto_rx_flit), .proto_rx_valid(proto_rx_valid), .proto_rx_ready(proto_rx_ready),
        .stack_enable(stack_enable), .fc_credits(fc_credits),
        .err_clear(err_clear), .drop_count(drop_count), .rx_error(rx_error),
        .demux_status(demux_status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; d2d_rx_valid = 1'b0; d2d_rx_flit = '0; d2d_rx_stack_id = '0;
        proto_rx_ready = '0; err_clear = 1'b0; stack_enable = 4'b1011;
        tick(); tick();
        n_checks++; if (proto_rx_valid !== 4'b0000) $display("FAIL reset_valid got=%b exp=0000", proto_rx_valid); else n_pass++;
        n_checks++; if (fc_credits[0] !== 8'd4) $display("FAIL reset_credit0 got=%0d exp=4", fc_credits[0]); else n_pass++;
        n_checks++; if (fc_credits[2] !== 8'd0) $display("FAIL reset_credit2 got=%0d exp=0", fc_credits[2]); else n_pass++;
        n_checks++; if (drop_count !== 16'd0 || rx_error !== 1'b0) $display("FAIL reset_err got=%0d/%b exp=0/0", drop_count, rx_error); else n_pass++;
        n_checks++; if (d2d_rx_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", d2d_rx_ready); else n_pass++;
        stack_enable = 4'b1111;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_routing();
        d2d_rx_flit = {8{8'hA5}}; d2d_rx_stack_id = 4'd2; d2d_rx_valid = 1'b1;
        tick();
        d2d_rx_valid = 1'b0;
        n_checks++; if (proto_rx_valid !== 4'b0100) $display("FAIL route_valid got=%b exp=0100", proto_rx_valid); else n_pass++;
        n_checks++; if (proto_rx_flit[2] !== {8{8'hA5}}) $display("FAIL route_flit got=%h exp=%h", proto_rx_flit[2], {8{8'hA5}}); else n_pass++;
        n_checks++; if (fc_credits[2] !== 8'd3) $display("FAIL route_credit got=%0d exp=3", fc_credits[2]); else n_pass++;
        proto_rx_ready[2] = 1'b1;
        tick();
        proto_rx_ready[2] = 1'b0;
        n_checks++; if (proto_rx_valid !== 4'b0000) $display("FAIL route_pop got=%b exp=0000", proto_rx_valid); else n_pass++;
    endtask

    task automatic test_full();
        d2d_rx_stack_id = 4'd0; d2d_rx_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d2d_rx_flit = 64'h10 + 64'(k);
            tick();
        end
        d2d_rx_flit = 64'h99;
        #1;
        n_checks++; if (d2d_rx_ready !== 1'b0) $display("FAIL full_ready got=%b exp=0", d2d_rx_ready); else n_pass++;
        n_checks++; if (fc_credits[0] !== 8'd0) $display("FAIL full_credit got=%0d exp=0", fc_credits[0]); else n_pass++;
        n_checks++; if (demux_status !== 16'h0001) $display("FAIL full_status got=%h exp=0001", demux_status); else n_pass++;
        proto_rx_ready[0] = 1'b1;
        #1;
        n_checks++; if (d2d_rx_ready !== 1'b0) $display("FAIL full_no_bypass got=%b exp=0", d2d_rx_ready); else n_pass++;
        tick();
        proto_rx_ready[0] = 1'b0;
        #1;
        n_checks++; if (d2d_rx_ready !== 1'b1) $display("FAIL full_reopen got=%b exp=1", d2d_rx_ready); else n_pass++;
        n_checks++; if (proto_rx_flit[0] !== 64'h11) $display("FAIL full_head got=%h exp=11", proto_rx_flit[0]); else n_pass++;
        tick();
        d2d_rx_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [63:0] exp;
            exp = (k == 3) ? 64'h99 : 64'h11 + 64'(k);
            n_checks++; if (proto_rx_flit[0] !== exp) $display("FAIL full_order%0d got=%h exp=%h", k, proto_rx_flit[0], exp); else n_pass++;
            proto_rx_ready[0] = 1'b1;
            tick();
            proto_rx_ready[0] = 1'b0;
        end
        n_checks++; if (proto_rx_valid[0] !== 1'b0) $display("FAIL full_drained got=%b exp=0", proto_rx_valid[0]); else n_pass++;
    endtask

    task automatic test_misroute();
        d2d_rx_stack_id = 4'd7; d2d_rx_flit = 64'hDEAD; d2d_rx_valid = 1'b1;
        #1;
        n_checks++; if (d2d_rx_ready !== 1'b1) $display("FAIL mis_ready got=%b exp=1", d2d_rx_ready); else n_pass++;
        tick();
        d2d_rx_valid = 1'b0;
        n_checks++; if (drop_count !== 16'd1 || rx_error !== 1'b1) $display("FAIL mis_count got=%0d/%b exp=1/1", drop_count, rx_error); else n_pass++;
        n_checks++; if (proto_rx_valid !== 4'b0000) $display("FAIL mis_valid got=%b exp=0000", proto_rx_valid); else n_pass++;
        n_checks++; if (demux_status !== 16'h8000) $display("FAIL mis_status got=%h exp=8000", demux_status); else n_pass++;
        stack_enable = 4'b1101; d2d_rx_stack_id = 4'd1; d2d_rx_valid = 1'b1;
        tick();
        d2d_rx_valid = 1'b0;
        n_checks++; if (drop_count !== 16'd2) $display("FAIL mis_disabled got=%0d exp=2", drop_count); else n_pass++;
        n_checks++; if (proto_rx_valid !== 4'b0000 || fc_credits[1] !== 8'd0) $display("FAIL mis_dis_state got=%b/%0d exp=0000/0", proto_rx_valid, fc_credits[1]); else n_pass++;
        stack_enable = 4'b1111;
    endtask

    task automatic test_clear_vs_drop();
        err_clear = 1'b1; d2d_rx_stack_id = 4'd7; d2d_rx_valid = 1'b1;
        tick();
        d2d_rx_valid = 1'b0;
        n_checks++; if (drop_count !== 16'd1 || rx_error !== 1'b1) $display("FAIL clr_drop got=%0d/%b exp=1/1", drop_count, rx_error); else n_pass++;
        tick();
        err_clear = 1'b0;
        n_checks++; if (drop_count !== 16'd0 || rx_error !== 1'b0) $display("FAIL clr_only got=%0d/%b exp=0/0", drop_count, rx_error); else n_pass++;
    endtask

    task automatic test_back_to_back();
        d2d_rx_stack_id = 4'd3; d2d_rx_valid = 1'b1;
        d2d_rx_flit = 64'h31; tick();
        d2d_rx_flit = 64'h32; tick();
        for (int k = 0; k < 4; k++) begin
            d2d_rx_flit = 64'h33 + 64'(k);
            proto_rx_ready[3] = 1'b1;
            n_checks++; if (proto_rx_flit[3] !== 64'h31 + 64'(k)) $display("FAIL b2b_head%0d got=%h exp=%h", k, proto_rx_flit[3], 64'h31 + 64'(k)); else n_pass++;
            tick();
            n_checks++; if (fc_credits[3] !== 8'd2) $display("FAIL b2b_credit%0d got=%0d exp=2", k, fc_credits[3]); else n_pass++;
        end
        d2d_rx_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (proto_rx_flit[3] !== 64'h35 + 64'(k)) $display("FAIL b2b_wrap%0d got=%h exp=%h", k, proto_rx_flit[3], 64'h35 + 64'(k)); else n_pass++;
            tick();
        end
        proto_rx_ready[3] = 1'b0;
        n_checks++; if (proto_rx_valid[3] !== 1'b0) $display("FAIL b2b_empty got=%b exp=0", proto_rx_valid[3]); else n_pass++;
    endtask

    task automatic test_flush_reset();
        d2d_rx_stack_id = 4'd1; d2d_rx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d2d_rx_flit = 64'h40 + 64'(k);
            tick();
        end
        d2d_rx_valid = 1'b0;
        n_checks++; if (fc_credits[1] !== 8'd1) $display("FAIL flush_pre got=%0d exp=1", fc_credits[1]); else n_pass++;
        stack_enable[1] = 1'b0;
        tick();
        n_checks++; if (proto_rx_valid[1] !== 1'b0 || fc_credits[1] !== 8'd0) $display("FAIL flush got=%b/%0d exp=0/0", proto_rx_valid[1], fc_credits[1]); else n_pass++;
        stack_enable[1] = 1'b1;
        tick();
        n_checks++; if (fc_credits[1] !== 8'd4 || proto_rx_valid[1] !== 1'b0) $display("FAIL flush_reen got=%0d/%b exp=4/0", fc_credits[1], proto_rx_valid[1]); else n_pass++;
        d2d_rx_valid = 1'b1;
        d2d_rx_stack_id = 4'd0; d2d_rx_flit = 64'h50; tick();
        d2d_rx_stack_id = 4'd2; d2d_rx_flit = 64'h51; tick();
        d2d_rx_stack_id = 4'd7; tick();
        n_checks++; if (proto_rx_valid !== 4'b0101 || drop_count !== 16'd1) $display("FAIL burst got=%b/%0d exp=0101/1", proto_rx_valid, drop_count); else n_pass++;
        rst = 1'b1; d2d_rx_valid = 1'b0;
        #1;
        n_checks++; if (proto_rx_valid !== 4'b0000) $display("FAIL rst_mid_valid got=%b exp=0000", proto_rx_valid); else n_pass++;
        n_checks++; if (fc_credits[0] !== 8'd4 || drop_count !== 16'd0 || rx_error !== 1'b0) $display("FAIL rst_mid_state got=%0d/%0d/%b exp=4/0/0", fc_credits[0], drop_count, rx_error); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (proto_rx_valid !== 4'b0000 || fc_credits[2] !== 8'd4) $display("FAIL rst_after got=%b/%0d exp=0000/4", proto_rx_valid, fc_credits[2]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_full();
        test_misroute();
        test_clear_vs_drop();
        test_back_to_back();
        test_flush_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
